// File: rtl/sseg_pkg.sv
// Shared types, constants and helpers for the multiplexed 7-segment display driver.
package sseg_pkg;

    localparam int unsigned SSEG_W      = 8;
    localparam int unsigned SSEG_DP_BIT = 7;
    localparam int unsigned MAX_DIGITS  = 32;

    localparam logic [SSEG_W-1:0] SSEG_OFF = 8'h00;

    typedef logic [SSEG_W-1:0] sseg_t;

    typedef enum logic {
        SCAN_ON,
        SCAN_BLANK
    } scan_state_e;

    // One-hot digit select; callers truncate to their digit count.
    function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx,
                                                     input int unsigned digits);
        logic [MAX_DIGITS-1:0] v;
        v = '0;
        if (idx < digits && idx < MAX_DIGITS) begin
            v = MAX_DIGITS'(1) << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/sseg_frame_buffer.sv
// Double buffer for segment data: loads land in pending and are promoted to
// active only at a frame boundary; a load on the boundary itself goes straight in.
module sseg_frame_buffer
    import sseg_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load_i,
    input  sseg_t [DIGITS-1:0]       data_i,
    input  logic                     frame_start_i,
    output sseg_t [DIGITS-1:0]       active_next_c
);

    sseg_t [DIGITS-1:0] pending_q, pending_d;
    sseg_t [DIGITS-1:0] active_q,  active_d;
    logic               pending_valid_q, pending_valid_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            active_q        <= '0;
        end else begin
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            active_q        <= active_d;
        end
    end

    always_comb begin
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        active_d        = active_q;
        if (frame_start_i) begin
            pending_valid_d = 1'b0;
            if (load_i) begin
                active_d = data_i;
            end else if (pending_valid_q) begin
                active_d = pending_q;
            end
        end else if (load_i) begin
            pending_d       = data_i;
            pending_valid_d = 1'b1;
        end
    end

    // Exposed pre-register so the scan outputs can show boundary data on the entry edge.
    assign active_next_c = active_d;

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed 7-segment scanner: per-digit ON slot followed by a blanking
// slot, with frame-aligned double-buffered segment data.
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned ON_CYCLES    = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [SSEG_W*DIGITS-1:0] in_sseg,
    input  logic                     load,
    input  logic [DIGITS-1:0]        digit_en,
    output logic [DIGITS-1:0]        an,
    output logic [SSEG_W-1:0]        sseg,
    output logic                     frame_done
);

    localparam int unsigned MAX_LEN = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned IDX_W   = $clog2(DIGITS);

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    scan_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [DIGITS-1:0]  an_q,    an_d;
    sseg_t              sseg_q,  sseg_d;
    logic               frame_done_q, frame_done_d;
    logic               frame_start_c;
    sseg_t [DIGITS-1:0] active_next_c;

    sseg_frame_buffer #(
        .DIGITS (DIGITS)
    ) u_frame_buffer (
        .clk           (clk),
        .reset_n       (reset_n),
        .load_i        (load),
        .data_i        (in_sseg),
        .frame_start_i (frame_start_c),
        .active_next_c (active_next_c)
    );

    // Reset parks in the last blanking cycle of the last digit so the first edge starts a frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= SCAN_BLANK;
            cnt_q        <= BLANK_LAST;
            idx_q        <= IDX_LAST;
            an_q         <= '0;
            sseg_q       <= SSEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            sseg_q       <= sseg_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        idx_d         = idx_q;
        frame_start_c = 1'b0;
        case (state_q)
            SCAN_ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d = SCAN_BLANK;
                    cnt_d   = '0;
                end
            end
            SCAN_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d       = SCAN_ON;
                    cnt_d         = '0;
                    idx_d         = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    frame_start_c = (idx_q == IDX_LAST);
                end
            end
            default: begin
                state_d = SCAN_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are computed from the next state so they register coincident with it.
    always_comb begin
        an_d         = '0;
        sseg_d       = SSEG_OFF;
        frame_done_d = 1'b0;
        if (state_d == SCAN_ON) begin
            an_d         = DIGITS'(onehot(32'(idx_d), DIGITS)) & digit_en;
            sseg_d       = digit_en[idx_d] ? active_next_c[idx_d] : SSEG_OFF;
            frame_done_d = frame_start_c;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Scoreboard bench for sseg_scan_mux: a timeline model predicts each cycle's outputs,
// a monitor compares them one cycle at a time.
module tb_sseg_scan_mux;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned ON_C   = 4;
    localparam int unsigned BLK_C  = 2;
    localparam int unsigned SLOT   = ON_C + BLK_C;
    localparam int unsigned FRAME  = DIGITS * SLOT;

    typedef struct {
        logic [DIGITS-1:0] an;
        logic [7:0]        sseg;
        logic              fd;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [8*DIGITS-1:0] in_sseg;
    logic                load;
    logic [DIGITS-1:0]   digit_en;
    logic [DIGITS-1:0]   an;
    logic [7:0]          sseg;
    logic                frame_done;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          t      = 0;
    logic [7:0]  m_act [DIGITS];
    logic [7:0]  m_pend[DIGITS];
    bit          m_pv   = 0;
    logic [3:0]  cur_en = 4'hF;

    sseg_scan_mux #(
        .DIGITS       (DIGITS),
        .ON_CYCLES    (ON_C),
        .BLANK_CYCLES (BLK_C)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_sseg    (in_sseg),
        .load       (load),
        .digit_en   (digit_en),
        .an         (an),
        .sseg       (sseg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Model: position within the frame decides digit and ON/BLANK; data follows the load rules.
    task automatic step(input bit ld, input logic [31:0] din, input logic [3:0] en, input bit rst);
        exp_t e;
        int   p;
        int   d;
        bit   on;
        @(negedge clk);
        load     = ld;
        in_sseg  = din;
        digit_en = en;
        if (rst) begin
            if (reset_n === 1'b1) begin
                reset_n = 1'b0;
                #1;
                check("async_an", 32'(an), 32'h0);
                check("async_sseg", 32'(sseg), 32'h0);
                check("async_fd", 32'(frame_done), 32'h0);
            end
            t    = 0;
            m_pv = 0;
            for (int k = 0; k < DIGITS; k++) begin
                m_act[k]  = 8'h00;
                m_pend[k] = 8'h00;
            end
            e.an   = '0;
            e.sseg = 8'h00;
            e.fd   = 1'b0;
        end else begin
            reset_n = 1'b1;
            p = t % FRAME;
            d = p / SLOT;
            if (p == 0) begin
                if (ld) begin
                    for (int k = 0; k < DIGITS; k++) m_act[k] = din[8*k +: 8];
                end else if (m_pv) begin
                    for (int k = 0; k < DIGITS; k++) m_act[k] = m_pend[k];
                end
                m_pv = 0;
            end else if (ld) begin
                for (int k = 0; k < DIGITS; k++) m_pend[k] = din[8*k +: 8];
                m_pv = 1;
            end
            on     = (p % SLOT) < ON_C;
            e.an   = (on && en[d]) ? DIGITS'(1 << d) : '0;
            e.sseg = (on && en[d]) ? m_act[d] : 8'h00;
            e.fd   = (p == 0);
            t++;
        end
        exp_q.push_back(e);
    endtask

    // Idle with random, unloaded input data until the next edge lands at frame position p.
    task automatic idle_to(input int p);
        while (int'(t % FRAME) != p) step(1'b0, $urandom, cur_en, 1'b0);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, cur_en, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("an", 32'(an), 32'(e.an));
                check("sseg", 32'(sseg), 32'(e.sseg));
                check("frame_done", 32'(frame_done), 32'(e.fd));
            end
        end
    end

    initial begin : stimulus
        reset_n  = 1'b0;
        load     = 1'b0;
        in_sseg  = '0;
        digit_en = 4'hF;
        #2;
        check("reset_an", 32'(an), 32'h0);
        check("reset_sseg", 32'(sseg), 32'h0);

        repeat (3) step(1'b0, 32'h0, cur_en, 1'b1);
        idle_n(30);

        idle_to(5);
        step(1'b1, 32'h796D307E, cur_en, 1'b0);
        idle_to(0);
        idle_n(FRAME);

        cur_en = 4'b1011;
        idle_to(0);
        idle_n(FRAME + 1);
        cur_en = 4'hF;

        idle_to(3);
        step(1'b1, 32'h7E7E7E7E, cur_en, 1'b0);
        idle_to(10);
        step(1'b1, 32'h4F4F4F4F, cur_en, 1'b0);
        idle_to(0);
        idle_n(FRAME);

        idle_to(0);
        step(1'b1, 32'h80808080, cur_en, 1'b0);
        idle_n(FRAME - 1);

        idle_to(14);
        step(1'b0, 32'h0, cur_en, 1'b1);
        step(1'b0, 32'h0, cur_en, 1'b1);
        idle_n(30);

        for (int i = 0; i < 300; i++) begin
            if ((i % 16) == 0) cur_en = 4'($urandom);
            step($urandom_range(0, 7) == 0, $urandom, cur_en, 1'b0);
        end

        repeat (2) @(posedge clk);
        #2;
        check("drain", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
